// File: rtl/video_sync_decoder_if.sv
// Sync/enable stream into the decoder and the recovered raster timing coming back out.
interface video_sync_decoder_if;
    logic        h_sync;
    logic        v_sync;
    logic        disp_enbl;
    logic [10:0] h_coord;
    logic [9:0]  v_coord;
    logic        coord_valid;
    logic        locked;
    logic        frame_start;
    logic        timing_err;
    logic [15:0] frame_cnt;

    modport master (
        output h_sync, v_sync, disp_enbl,
        input  h_coord, v_coord, coord_valid, locked, frame_start, timing_err, frame_cnt
    );

    modport slave (
        input  h_sync, v_sync, disp_enbl,
        output h_coord, v_coord, coord_valid, locked, frame_start, timing_err, frame_cnt
    );
endinterface

// File: rtl/video_sync_decoder.sv
// Recovers pixel coordinates from h_sync/v_sync/disp_enbl and locks once the
// measured line and frame timing matches the configured raster.
module video_sync_decoder #(
    parameter int H_ACTIVE         = 800,
    parameter int V_ACTIVE         = 600,
    parameter int H_TOTAL          = 1024,
    parameter int V_TOTAL          = 625,
    parameter bit SYNC_ACTIVE_HIGH = 1'b1,
    parameter int LOCK_FRAMES      = 2
) (
    input logic                 pixel_clk,
    input logic                 rst,
    video_sync_decoder_if.slave vid
);
    localparam logic [10:0] H_ACTIVE_W = 11'(H_ACTIVE);
    localparam logic [10:0] H_TOTAL_W  = 11'(H_TOTAL);
    localparam logic [9:0]  V_ACTIVE_W = 10'(V_ACTIVE);
    localparam logic [9:0]  V_TOTAL_W  = 10'(V_TOTAL);
    localparam logic [3:0]  LOCK_LAST  = 4'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state;
    logic [3:0]  good_frames;

    logic        h_smp, v_smp, de_smp;
    logic        h_prev, v_prev, de_prev;
    logic        h_seen;
    logic [10:0] line_period;
    logic [10:0] de_run;
    logic [9:0]  de_falls;
    logic [9:0]  h_edges;
    logic        line_err_seen;

    logic [10:0] h_coord_q;
    logic [9:0]  v_coord_q;
    logic        coord_valid_q;
    logic        locked_q;
    logic        frame_start_q;
    logic        timing_err_q;
    logic [15:0] frame_cnt_q;

    logic        h_edge, v_edge, de_rise, de_fall, de_hold;
    logic        line_err_now, frame_good;
    logic [9:0]  de_falls_cl, h_edges_cl;

    function automatic logic [10:0] sat_inc11(input logic [10:0] val);
        return (val == '1) ? val : val + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] val);
        return (val == '1) ? val : val + 10'd1;
    endfunction

    // History is kept post-polarity, so a zeroed register always means "inactive".
    assign h_smp  = SYNC_ACTIVE_HIGH ? vid.h_sync : ~vid.h_sync;
    assign v_smp  = SYNC_ACTIVE_HIGH ? vid.v_sync : ~vid.v_sync;
    assign de_smp = vid.disp_enbl;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        h_edge  = h_smp & ~h_prev;
        v_edge  = v_smp & ~v_prev;
        de_rise = de_smp & ~de_prev;
        de_fall = ~de_smp & de_prev;
        de_hold = de_smp & de_prev;

        de_falls_cl = de_fall ? sat_inc10(de_falls) : de_falls;
        h_edges_cl  = h_edge  ? sat_inc10(h_edges)  : h_edges;

        line_err_now = (de_fall && (de_run != H_ACTIVE_W)) ||
                       (h_edge && h_seen && (line_period != H_TOTAL_W));

        // Events in the closing cycle still belong to the frame being judged.
        frame_good = !line_err_seen && !line_err_now &&
                     (de_falls_cl == V_ACTIVE_W) && (h_edges_cl == V_TOTAL_W);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            h_prev        <= 1'b0;
            v_prev        <= 1'b0;
            de_prev       <= 1'b0;
            h_seen        <= 1'b0;
            line_period   <= '0;
            de_run        <= '0;
            de_falls      <= '0;
            h_edges       <= '0;
            line_err_seen <= 1'b0;
            h_coord_q     <= '0;
            v_coord_q     <= '0;
            coord_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_prev  <= h_smp;
            v_prev  <= v_smp;
            de_prev <= de_smp;

            if (h_edge) h_seen <= 1'b1;
            line_period <= h_edge ? 11'd1 : sat_inc11(line_period);

            if (de_rise)      de_run <= 11'd1;
            else if (de_hold) de_run <= sat_inc11(de_run);

            if (v_edge) begin
                de_falls      <= '0;
                h_edges       <= '0;
                line_err_seen <= 1'b0;
            end else begin
                de_falls      <= de_falls_cl;
                h_edges       <= h_edges_cl;
                line_err_seen <= line_err_seen | line_err_now;
            end

            coord_valid_q <= de_smp;
            frame_start_q <= v_edge;

            if (de_rise)      h_coord_q <= '0;
            else if (de_hold) h_coord_q <= sat_inc11(h_coord_q);

            if (v_edge)       v_coord_q <= '0;
            else if (de_fall) v_coord_q <= sat_inc10(v_coord_q);
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state        <= SEARCH;
            good_frames  <= '0;
            locked_q     <= 1'b0;
            timing_err_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            timing_err_q <= 1'b0;
            case (state)
                SEARCH: begin
                    if (v_edge) begin
                        state       <= MEASURE;
                        good_frames <= '0;
                    end
                end
                MEASURE: begin
                    if (v_edge) begin
                        if (!frame_good) begin
                            good_frames <= '0;
                        end else if (good_frames == LOCK_LAST) begin
                            state       <= LOCKED;
                            locked_q    <= 1'b1;
                            good_frames <= '0;
                        end else begin
                            good_frames <= good_frames + 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (line_err_now || (v_edge && !frame_good)) begin
                        state        <= MEASURE;
                        locked_q     <= 1'b0;
                        timing_err_q <= 1'b1;
                        good_frames  <= '0;
                    end else if (v_edge) begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state       <= SEARCH;
                    locked_q    <= 1'b0;
                    good_frames <= '0;
                end
            endcase
        end
    end

    assign vid.h_coord     = h_coord_q;
    assign vid.v_coord     = v_coord_q;
    assign vid.coord_valid = coord_valid_q;
    assign vid.locked      = locked_q;
    assign vid.frame_start = frame_start_q;
    assign vid.timing_err  = timing_err_q;
    assign vid.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_video_sync_decoder.sv
// Drives a small raster (with injected faults and resets) into an active-high and an
// active-low decoder and compares both against an event/timestamp reference model.
module tb_video_sync_decoder;
    localparam int HA = 8;
    localparam int VA = 6;
    localparam int HT = 16;
    localparam int VT = 10;
    localparam int LF = 2;

    logic pixel_clk;
    logic rst;

    video_sync_decoder_if vif_a ();
    video_sync_decoder_if vif_b ();

    video_sync_decoder #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
        .SYNC_ACTIVE_HIGH(1'b1), .LOCK_FRAMES(LF)
    ) dut_a (
        .pixel_clk(pixel_clk),
        .rst      (rst),
        .vid      (vif_a.slave)
    );

    video_sync_decoder #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
        .SYNC_ACTIVE_HIGH(1'b0), .LOCK_FRAMES(LF)
    ) dut_b (
        .pixel_clk(pixel_clk),
        .rst      (rst),
        .vid      (vif_b.slave)
    );

    initial pixel_clk = 1'b0;
    always #14 pixel_clk = ~pixel_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference model: timestamps of the last edges plus per-frame tallies.
    int          m_cyc;
    bit          m_ph, m_pv, m_pde;
    int          m_last_h;
    int          m_rise;
    int          m_falls;
    int          m_hedges;
    bit          m_bad;
    int          m_streak;
    logic [10:0] e_hc;
    logic [9:0]  e_vc;
    logic        e_cv, e_lk, e_fs, e_te;
    logic [15:0] e_fc;

    int          v_since_rst;
    int          lock_at;
    int          te_seen;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_reset();
        m_cyc = 0; m_ph = 0; m_pv = 0; m_pde = 0;
        m_last_h = -1; m_rise = 0; m_falls = 0; m_hedges = 0; m_bad = 0;
        m_streak = -1;
        e_hc = '0; e_vc = '0; e_cv = 0; e_lk = 0; e_fs = 0; e_te = 0; e_fc = '0;
    endfunction

    function automatic void model_step(input bit h, input bit v, input bit de);
        bit he, ve, rise, fall, lerr, good, was_locked;
        he   = h && !m_ph;
        ve   = v && !m_pv;
        rise = de && !m_pde;
        fall = !de && m_pde;
        lerr = 0;
        was_locked = (m_streak >= LF);
        if (rise) m_rise = m_cyc;
        if (fall && min_i(m_cyc - m_rise, 2047) != HA) lerr = 1;
        if (he && m_last_h >= 0 && min_i(m_cyc - m_last_h, 2047) != HT) lerr = 1;
        if (he) begin
            m_hedges++;
            m_last_h = m_cyc;
        end
        if (fall) m_falls++;
        m_bad = m_bad | lerr;
        e_cv = de;
        e_fs = ve;
        e_te = 0;
        if (de) e_hc = 11'(min_i(m_cyc - m_rise, 2047));
        e_vc = ve ? 10'd0 : 10'(min_i(m_falls, 1023));
        if (ve) begin
            good = !m_bad && min_i(m_falls, 1023) == VA && min_i(m_hedges, 1023) == VT;
            if (m_streak < 0) m_streak = 0;
            else if (good) begin
                if (was_locked) e_fc = e_fc + 16'd1;
                m_streak++;
            end else begin
                if (was_locked) e_te = 1;
                m_streak = 0;
            end
            m_falls = 0; m_hedges = 0; m_bad = 0;
        end
        if (lerr && was_locked) begin
            e_te = 1;
            m_streak = 0;
        end
        e_lk = (m_streak >= LF);
        m_ph = h; m_pv = v; m_pde = de;
        m_cyc++;
    endfunction

    task automatic compare_outs(input string pfx, input logic [10:0] hc, input logic [9:0] vc,
                                input logic cv, input logic lk, input logic fs, input logic te,
                                input logic [15:0] fc);
        check({pfx, ".h_coord"},     64'(hc), 64'(e_hc));
        check({pfx, ".v_coord"},     64'(vc), 64'(e_vc));
        check({pfx, ".coord_valid"}, 64'(cv), 64'(e_cv));
        check({pfx, ".locked"},      64'(lk), 64'(e_lk));
        check({pfx, ".frame_start"}, 64'(fs), 64'(e_fs));
        check({pfx, ".timing_err"},  64'(te), 64'(e_te));
        check({pfx, ".frame_cnt"},   64'(fc), 64'(e_fc));
    endtask

    task automatic compare_both(input string pfx);
        compare_outs({pfx, ".a"}, vif_a.h_coord, vif_a.v_coord, vif_a.coord_valid, vif_a.locked,
                     vif_a.frame_start, vif_a.timing_err, vif_a.frame_cnt);
        compare_outs({pfx, ".b"}, vif_b.h_coord, vif_b.v_coord, vif_b.coord_valid, vif_b.locked,
                     vif_b.frame_start, vif_b.timing_err, vif_b.frame_cnt);
    endtask

    task automatic cycle(input bit h, input bit v, input bit de);
        bit ve;
        ve = v && !m_pv;
        vif_a.h_sync = h;  vif_a.v_sync = v;  vif_a.disp_enbl = de;
        vif_b.h_sync = !h; vif_b.v_sync = !v; vif_b.disp_enbl = de;
        model_step(h, v, de);
        @(posedge pixel_clk);
        #1;
        if (ve) v_since_rst++;
        if (vif_a.timing_err) te_seen++;
        if (vif_a.locked && lock_at < 0) lock_at = v_since_rst;
        compare_both("cyc");
    endtask

    // Reset lands mid-cycle, well away from either clock edge.
    task automatic async_reset();
        #9 rst = 1'b1;
        #3;
        model_reset();
        v_since_rst = 0;
        lock_at = -1;
        compare_both("rst_async");
        repeat (2) @(posedge pixel_clk);
        #1;
        compare_both("rst_hold");
        #4 rst = 1'b0;
    endtask

    task automatic run_line(input int de_len, input int period, input int vmode, input int voff,
                            input int rst_x);
        for (int x = 0; x < period; x++) begin
            if (x == rst_x) async_reset();
            cycle(x < 2, (vmode == 2) || (vmode == 1 && x >= voff), (x >= 4) && (x < 4 + de_len));
        end
    endtask

    // mode: 0 clean, 1 short de line, 2 long line period, 3 extra active line, 4 missing line
    task automatic run_frame(input int mode, input int voff, input int rst_line);
        int lines, nact, de_len, period, vmode;
        lines = (mode == 4) ? VT - 1 : VT;
        nact  = (mode == 3) ? VA + 1 : VA;
        for (int y = 0; y < lines; y++) begin
            de_len = (y >= 3 && y < 3 + nact) ? ((mode == 1 && y == 5) ? HA - 1 : HA) : 0;
            period = (mode == 2 && y == 6) ? HT + 1 : HT;
            vmode  = (y == 0) ? 1 : ((y == 1) ? 2 : 0);
            run_line(de_len, period, vmode, voff, (y == rst_line) ? 7 : -1);
        end
    endtask

    initial begin
        int te_base;
        logic [15:0] fc_base;
        int r, mode, voff, rl;

        rst = 1'b1;
        vif_a.h_sync = 1'b0; vif_a.v_sync = 1'b0; vif_a.disp_enbl = 1'b0;
        vif_b.h_sync = 1'b1; vif_b.v_sync = 1'b1; vif_b.disp_enbl = 1'b0;
        model_reset();
        v_since_rst = 0;
        lock_at = -1;
        te_seen = 0;
        repeat (3) @(posedge pixel_clk);
        #1;
        compare_both("rst_init");
        #4 rst = 1'b0;

        for (int f = 0; f < 5; f++) run_frame(0, 5, -1);
        check("lock_edges", 64'(lock_at), 64'(LF + 1));
        check("frame_cnt_5f", 64'(vif_a.frame_cnt), 64'd2);

        te_base = te_seen;
        run_frame(1, 5, -1);
        check("short_line_err", 64'(te_seen - te_base), 64'd1);
        check("unlock_after_err", 64'(vif_a.locked), 64'd0);
        run_frame(0, 5, -1);
        run_frame(0, 5, -1);
        check("still_measuring", 64'(vif_a.locked), 64'd0);
        run_frame(0, 5, -1);
        check("relocked", 64'(vif_a.locked), 64'd1);

        te_base = te_seen;
        fc_base = vif_a.frame_cnt;
        for (int f = 0; f < 3; f++) run_frame(0, 0, -1);
        check("sim_edge_no_err", 64'(te_seen - te_base), 64'd0);
        check("sim_edge_frames", 64'(16'(vif_a.frame_cnt - fc_base)), 64'd3);

        run_frame(0, 5, 4);
        for (int f = 0; f < 3; f++) run_frame(0, 5, -1);
        check("relock_after_rst", 64'(lock_at), 64'(LF + 1));

        for (int i = 0; i < 2100; i++) cycle(1'b0, 1'b0, 1'b1);
        check("h_coord_sat", 64'(vif_a.h_coord), 64'd2047);
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1030; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0);
        end
        check("v_coord_sat", 64'(vif_a.v_coord), 64'd1023);
        for (int f = 0; f < 4; f++) run_frame(0, 5, -1);

        for (int f = 0; f < 40; f++) begin
            r = int'($urandom_range(0, 8));
            mode = (r < 5) ? 0 : r - 4;
            case ($urandom_range(0, 2))
                0:       voff = 0;
                1:       voff = 5;
                default: voff = 9;
            endcase
            rl = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 9)) : -1;
            run_frame(mode, voff, rl);
        end
        for (int f = 0; f < 4; f++) run_frame(0, 5, -1);
        check("final_locked", 64'(vif_a.locked), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
